alu_share_arb: RTL

Two-requester arbiter and sequencer that time-shares one combinational 32-bit ALU (alu32) inside the MIPS datapath. It accepts level-held requests from two clients (e.g. main execute path and branch/address unit), grants them round-robin, registers operands into the shared ALU, captures the ALU result and zero flag, and returns them with a one-cycle acknowledge. The ALU itself stays outside the block; this block drives its inputs and samples its outputs.

---
 rtl/alu_share_arb.sv | 127 ++++++++++++
 1 files changed

// File: rtl/alu_share_arb.sv
// Round-robin arbiter/sequencer time-sharing one external alu32.
// Optional op_cnt counter enabled by ALU_ARB_STATS_EN.
module alu_share_arb #(
  parameter int CNT_W = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req0,
  input  logic        req1,
  input  logic [31:0] a0,
  input  logic [31:0] b0,
  input  logic [2:0]  code0,
  input  logic [31:0] a1,
  input  logic [31:0] b1,
  input  logic [2:0]  code1,
  output logic        ack0,
  output logic        ack1,
  output logic [31:0] result,
  output logic        zero,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  output logic [2:0]  alu_code,
  input  logic [31:0] alu_out,
  input  logic        alu_zero,
  output logic        busy
`ifdef ALU_ARB_STATS_EN
 ,output logic [CNT_W-1:0] op_cnt
`endif
);

  typedef enum logic [1:0] {
    IDLE, EXEC, DONE
  } state_t;

  state_t      state_q, state_d;
  logic        gnt_q, gnt_d;
  logic        last_q, last_d;
  logic [31:0] alu_a_q, alu_a_d;
  logic [31:0] alu_b_q, alu_b_d;
  logic [2:0]  code_q, code_d;
  logic [31:0] result_q, result_d;
  logic        zero_q, zero_d;
  logic        pick;
`ifdef ALU_ARB_STATS_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;
`endif

  always_comb begin
    state_d  = state_q;
    gnt_d    = gnt_q;
    last_d   = last_q;
    alu_a_d  = alu_a_q;
    alu_b_d  = alu_b_q;
    code_d   = code_q;
    result_d = result_q;
    zero_d   = zero_q;
`ifdef ALU_ARB_STATS_EN
    cnt_d    = cnt_q;
`endif
    pick = (req0 & req1) ? ~last_q : req1;
    unique case (state_q)
      IDLE: begin
        if (req0 | req1) begin
          gnt_d   = pick;
          last_d  = pick;
          alu_a_d = pick ? a1 : a0;
          alu_b_d = pick ? b1 : b0;
          code_d  = pick ? code1 : code0;
          state_d = EXEC;
        end
      end
      EXEC: begin
        result_d = alu_out;
        zero_d   = alu_zero;
        state_d  = DONE;
      end
      DONE: begin
        state_d = IDLE;
`ifdef ALU_ARB_STATS_EN
        cnt_d   = cnt_q + 1'b1;
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      gnt_q    <= 1'b0;
      last_q   <= 1'b1;
      alu_a_q  <= '0;
      alu_b_q  <= '0;
      code_q   <= '0;
      result_q <= '0;
      zero_q   <= 1'b0;
`ifdef ALU_ARB_STATS_EN
      cnt_q    <= '0;
`endif
    end else begin
      state_q  <= state_d;
      gnt_q    <= gnt_d;
      last_q   <= last_d;
      alu_a_q  <= alu_a_d;
      alu_b_q  <= alu_b_d;
      code_q   <= code_d;
      result_q <= result_d;
      zero_q   <= zero_d;
`ifdef ALU_ARB_STATS_EN
      cnt_q    <= cnt_d;
`endif
    end
  end

  assign ack0     = (state_q == DONE) & ~gnt_q;
  assign ack1     = (state_q == DONE) & gnt_q;
  assign busy     = (state_q != IDLE);
  assign result   = result_q;
  assign zero     = zero_q;
  assign alu_a    = alu_a_q;
  assign alu_b    = alu_b_q;
  assign alu_code = code_q;
`ifdef ALU_ARB_STATS_EN
  assign op_cnt   = cnt_q;
`endif

endmodule
